// File: rtl/dmem_mmio.sv
// Data memory for the single-cycle MIPS core: word RAM in the low half, UART TX MMIO in the high half.
// Define DMEM_CYCLE_COUNTER_EN to add the free-running CYCLE counter at offset 0xC.
module dmem_mmio #(
   parameter int RAM_AW       = 6,
   parameter int FIFO_AW      = 2,
   parameter int CLKS_PER_BIT = 16
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        we,
   input  logic [31:0] a,
   input  logic [31:0] wd,
   output logic [31:0] rd,
   output logic        tx
);
   localparam int                RAM_D     = 1 << RAM_AW;
   localparam int                FIFO_D    = 1 << FIFO_AW;
   localparam logic [FIFO_AW:0]  FIFO_FULL = (FIFO_AW+1)'(FIFO_D);
   localparam logic [FIFO_AW:0]  CNT_ZERO  = {(FIFO_AW+1){1'b0}};
   localparam logic [FIFO_AW:0]  CNT_ONE   = (FIFO_AW+1)'(1);
   localparam logic [FIFO_AW-1:0] PTR_ONE  = (FIFO_AW)'(1);
   localparam logic [15:0]       BAUD_RST  = 16'(CLKS_PER_BIT);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_START = 2'd1,
      S_DATA  = 2'd2,
      S_STOP  = 2'd3
   } state_t;

   logic [31:0]        ram_q [RAM_D];
   logic [7:0]         fifo_q [FIFO_D];
   logic [FIFO_AW-1:0] wptr_q, rptr_q;
   logic [FIFO_AW:0]   cnt_q, cnt_d;
   logic [15:0]        baud_q, div_q, timer_q;
   logic [7:0]         shreg_q;
   logic [2:0]         bitcnt_q;
   state_t             state_q;
   logic               tx_q;

   logic        mmio_s, ram_we_s, push_s, pop_s, full_s, empty_s, busy_s, bit_end_s;
   logic        baud_we_s, cyc_we_s;
   logic [31:0] cyc_rd_s;
   logic        unused_s;

   assign mmio_s    = a[31];
   assign ram_we_s  = we & ~mmio_s;
   assign baud_we_s = we & mmio_s & (a[4:2] == 3'd2);
   assign cyc_we_s  = we & mmio_s & (a[4:2] == 3'd3);
   assign full_s    = (cnt_q == FIFO_FULL);
   assign empty_s   = (cnt_q == CNT_ZERO);
   assign busy_s    = (state_q != S_IDLE);
   assign bit_end_s = (timer_q == 16'd0);
   // Popping at the end of STOP lets queued frames follow with no idle gap.
   assign pop_s     = ~empty_s & ((state_q == S_IDLE) | ((state_q == S_STOP) & bit_end_s));
   assign push_s    = we & mmio_s & (a[4:2] == 3'd0) & (~full_s | pop_s);
   assign tx        = tx_q;
   assign unused_s  = ^a[30:0];

   // RAM storage, never reset
   always_ff @(posedge clk) begin
      if (ram_we_s) begin
         ram_q[a[RAM_AW+1:2]] <= wd;
      end
   end

   // FIFO occupancy next state
   always_comb begin
      cnt_d = cnt_q;
      case ({push_s, pop_s})
         2'b10:   cnt_d = cnt_q + CNT_ONE;
         2'b01:   cnt_d = cnt_q - CNT_ONE;
         default: cnt_d = cnt_q;
      endcase
   end

   // FIFO data storage
   always_ff @(posedge clk) begin
      if (push_s) begin
         fifo_q[wptr_q] <= wd[7:0];
      end
   end

   // FIFO pointers and count
   always_ff @(posedge clk) begin
      if (reset) begin
         wptr_q <= {FIFO_AW{1'b0}};
         rptr_q <= {FIFO_AW{1'b0}};
         cnt_q  <= CNT_ZERO;
      end else begin
         if (push_s) wptr_q <= wptr_q + PTR_ONE;
         if (pop_s)  rptr_q <= rptr_q + PTR_ONE;
         cnt_q <= cnt_d;
      end
   end

   // BAUD_DIV register; zero would stall the bit timer so it is stored as one
   always_ff @(posedge clk) begin
      if (reset) begin
         baud_q <= BAUD_RST;
      end else if (baud_we_s) begin
         baud_q <= (wd[15:0] == 16'd0) ? 16'd1 : wd[15:0];
      end
   end

   // Serializer FSM with registered line output
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= S_IDLE;
         tx_q     <= 1'b1;
         timer_q  <= 16'd0;
         div_q    <= BAUD_RST;
         shreg_q  <= 8'd0;
         bitcnt_q <= 3'd0;
      end else if (pop_s) begin
         state_q  <= S_START;
         tx_q     <= 1'b0;
         shreg_q  <= fifo_q[rptr_q];
         div_q    <= baud_q;
         timer_q  <= baud_q - 16'd1;
         bitcnt_q <= 3'd0;
      end else begin
         case (state_q)
            S_IDLE: begin
               tx_q <= 1'b1;
            end
            S_START: begin
               if (bit_end_s) begin
                  tx_q    <= shreg_q[0];
                  shreg_q <= {1'b0, shreg_q[7:1]};
                  timer_q <= div_q - 16'd1;
                  state_q <= S_DATA;
               end else begin
                  timer_q <= timer_q - 16'd1;
               end
            end
            S_DATA: begin
               if (bit_end_s) begin
                  timer_q <= div_q - 16'd1;
                  if (bitcnt_q == 3'd7) begin
                     tx_q    <= 1'b1;
                     state_q <= S_STOP;
                  end else begin
                     tx_q     <= shreg_q[0];
                     shreg_q  <= {1'b0, shreg_q[7:1]};
                     bitcnt_q <= bitcnt_q + 3'd1;
                  end
               end else begin
                  timer_q <= timer_q - 16'd1;
               end
            end
            S_STOP: begin
               if (bit_end_s) begin
                  state_q <= S_IDLE;
               end else begin
                  timer_q <= timer_q - 16'd1;
               end
            end
            default: begin
               state_q <= S_IDLE;
               tx_q    <= 1'b1;
            end
         endcase
      end
   end

`ifdef DMEM_CYCLE_COUNTER_EN
   logic [31:0] cyc_q;

   // Free-running cycle counter, loadable by store
   always_ff @(posedge clk) begin
      if (reset) begin
         cyc_q <= 32'd0;
      end else if (cyc_we_s) begin
         cyc_q <= wd;
      end else begin
         cyc_q <= cyc_q + 32'd1;
      end
   end

   assign cyc_rd_s = cyc_q;
`else
   logic unused_cyc_s;

   assign unused_cyc_s = cyc_we_s;
   assign cyc_rd_s     = 32'd0;
`endif

   // Combinational load data mux
   always_comb begin
      rd = 32'd0;
      if (!mmio_s) begin
         rd = ram_q[a[RAM_AW+1:2]];
      end else begin
         case (a[4:2])
            3'd1:    rd = {29'd0, busy_s, empty_s, full_s};
            3'd2:    rd = {16'd0, baud_q};
            3'd3:    rd = cyc_rd_s;
            default: rd = 32'd0;
         endcase
      end
   end
endmodule

// File: tb/tb_dmem_mmio.sv
// Self-checking bench for dmem_mmio: frame-level UART model, RAM map and MMIO register model.
module tb_dmem_mmio;
   localparam int RAM_AW = 6;
   localparam int DEPTH  = 4;

   logic        clk = 1'b0;
   logic        reset, we, tx;
   logic [31:0] a, wd, rd;
   int          total = 0;
   int          bad   = 0;

   dmem_mmio #(.RAM_AW(6), .FIFO_AW(2), .CLKS_PER_BIT(16)) dut (
      .clk(clk), .reset(reset), .we(we), .a(a), .wd(wd), .rd(rd), .tx(tx)
   );

   always #5 clk = ~clk;

   // Reference model: sparse RAM, byte queue, one frame in flight timed by elapsed cycles
   logic [31:0] ram_m [int];
   logic [7:0]  q_m [$];
   bit          act_m = 1'b0;
   logic [7:0]  byte_m;
   int          div_l_m = 1, el_m = 0, baud_m = 16;
   logic [31:0] cyc_m = 32'd0;
   logic [31:0] waddr [$];

   task automatic tick(input logic r, input logic w, input logic [31:0] addr, input logic [31:0] data);
      bit ending, pop_en;
      logic [7:0] head;
      reset = r; we = w; a = addr; wd = data;
      @(posedge clk);
      if (w && !addr[31]) ram_m[int'(addr[RAM_AW+1:2])] = data;
      if (r) begin
         q_m.delete(); act_m = 1'b0; baud_m = 16; cyc_m = 32'd0;
      end else begin
         ending = act_m && (el_m == 10 * div_l_m - 1);
         pop_en = (!act_m || ending) && (q_m.size() > 0);
         head   = 8'd0;
         if (pop_en) head = q_m.pop_front();
         if (w && addr[31] && addr[4:2] == 3'd0 && q_m.size() < DEPTH) q_m.push_back(data[7:0]);
         if (pop_en) begin
            act_m = 1'b1; byte_m = head; el_m = 0; div_l_m = baud_m;
         end else if (ending) begin
            act_m = 1'b0;
         end else if (act_m) begin
            el_m++;
         end
         if (w && addr[31] && addr[4:2] == 3'd2) baud_m = (data[15:0] == 16'd0) ? 1 : int'(data[15:0]);
         if (w && addr[31] && addr[4:2] == 3'd3) cyc_m = data;
         else cyc_m = cyc_m + 32'd1;
      end
      #1;
   endtask

   task automatic setrd(input logic [31:0] addr);
      we = 1'b0; a = addr; #1;
   endtask

   function automatic logic m_tx();
      int idx;
      if (!act_m) return 1'b1;
      idx = el_m / div_l_m;
      if (idx == 0) return 1'b0;
      if (idx <= 8) return byte_m[idx-1];
      return 1'b1;
   endfunction

   function automatic logic [31:0] m_rd(input logic [31:0] addr);
      if (!addr[31]) return ram_m[int'(addr[RAM_AW+1:2])];
      case (addr[4:2])
         3'd1:    return {29'd0, act_m, q_m.size() == 0, q_m.size() == DEPTH};
         3'd2:    return 32'(baud_m);
`ifdef DMEM_CYCLE_COUNTER_EN
         3'd3:    return cyc_m;
`endif
         default: return 32'd0;
      endcase
   endfunction

   task automatic test_reset();
      logic [31:0] exp;
      tick(1'b1, 1'b0, 32'd0, 32'd0);
      tick(1'b1, 1'b0, 32'd0, 32'd0);
      total++; if (tx !== 1'b1) begin bad++; $display("FAIL rst_tx got=%b exp=1", tx); end
      setrd(32'h8000_0004);
      total++; if (rd !== 32'h2) begin bad++; $display("FAIL rst_status got=%h exp=2", rd); end
      setrd(32'h8000_0008);
      total++; if (rd !== 32'd16) begin bad++; $display("FAIL rst_baud got=%h exp=10", rd); end
      setrd(32'h8000_000C);
      total++; if (rd !== 32'd0) begin bad++; $display("FAIL rst_cycle got=%h exp=0", rd); end
      tick(1'b0, 1'b0, 32'h8000_000C, 32'd0);
`ifdef DMEM_CYCLE_COUNTER_EN
      exp = 32'd1;
`else
      exp = 32'd0;
`endif
      total++; if (rd !== exp) begin bad++; $display("FAIL cycle_after_rst got=%h exp=%h", rd, exp); end
   endtask

   task automatic test_ram();
      logic [31:0] v14, ad, al;
      v14 = $urandom;
      tick(1'b0, 1'b1, 32'h0000_0014, v14);
      tick(1'b0, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF);
      setrd(32'h0000_0010);
      total++; if (rd !== 32'hDEAD_BEEF) begin bad++; $display("FAIL ram_10 got=%h exp=deadbeef", rd); end
      setrd(32'h0000_0110);
      total++; if (rd !== 32'hDEAD_BEEF) begin bad++; $display("FAIL ram_alias got=%h exp=deadbeef", rd); end
      setrd(32'h0000_0014);
      total++; if (rd !== v14) begin bad++; $display("FAIL ram_14 got=%h exp=%h", rd, v14); end
      setrd(32'h8000_0000);
      total++; if (rd !== 32'd0) begin bad++; $display("FAIL uart_data_rd got=%h exp=0", rd); end
      for (int i = 0; i < 16; i++) begin
         ad = $urandom & 32'h7FFF_FFFF;
         tick(1'b0, 1'b1, ad, $urandom);
         waddr.push_back(ad);
         al = (ad & 32'h0000_00FC) | ($urandom & 32'h7FFF_FF03);
         setrd(al);
         total++; if (rd !== m_rd(al)) begin bad++; $display("FAIL ram_rand a=%h got=%h exp=%h", al, rd, m_rd(al)); end
      end
   endtask

   task automatic test_single_frame();
      logic [9:0] pat;
      logic       e;
      logic [31:0] es;
      pat = {1'b1, 8'h55, 1'b0};
      tick(1'b0, 1'b1, 32'h8000_0008, 32'd4);
      tick(1'b0, 1'b1, 32'h8000_0000, 32'h0000_0055);
      setrd(32'h8000_0004);
      total++; if (rd !== 32'h0) begin bad++; $display("FAIL sf_status_push got=%h exp=0", rd); end
      for (int k = 0; k < 45; k++) begin
         tick(1'b0, 1'b0, 32'h8000_0004, 32'd0);
         e  = (k < 40) ? pat[k/4] : 1'b1;
         es = (k < 40) ? 32'h6 : 32'h2;
         total++; if (tx !== e) begin bad++; $display("FAIL sf_tx k=%0d got=%b exp=%b", k, tx, e); end
         total++; if (rd !== es) begin bad++; $display("FAIL sf_status k=%0d got=%h exp=%h", k, rd, es); end
      end
   endtask

   task automatic test_back_to_back();
      logic log_tx [0:215];
      logic [7:0] b;
      bit idle_ok;
      for (int i = 0; i < 6; i++) begin
         tick(1'b0, 1'b1, 32'h8000_0000, 32'h41 + 32'(i));
         log_tx[i] = tx;
      end
      setrd(32'h8000_0004);
      total++; if (rd !== 32'h5) begin bad++; $display("FAIL b2b_full got=%h exp=5", rd); end
      for (int i = 6; i < 216; i++) begin
         tick(1'b0, 1'b0, 32'd0, 32'd0);
         log_tx[i] = tx;
         total++; if (tx !== m_tx()) begin bad++; $display("FAIL b2b_tx i=%0d got=%b exp=%b", i, tx, m_tx()); end
      end
      for (int f = 0; f < 5; f++) begin
         for (int i = 0; i < 8; i++) b[i] = log_tx[1 + 40*f + 4*(i+1) + 2];
         total++;
         if (log_tx[1 + 40*f] !== 1'b0 || log_tx[1 + 40*f + 38] !== 1'b1 || b !== 8'h41 + 8'(f)) begin
            bad++; $display("FAIL b2b_frame f=%0d got=%h exp=%h", f, b, 8'h41 + 8'(f));
         end
      end
      idle_ok = 1'b1;
      for (int i = 201; i < 216; i++) if (log_tx[i] !== 1'b1) idle_ok = 1'b0;
      total++; if (!idle_ok) begin bad++; $display("FAIL b2b_extra_frame got=activity exp=idle"); end
   endtask

   task automatic test_baud();
      logic log_tx [0:135];
      logic [7:0] va, vb, ga, gb;
      tick(1'b0, 1'b1, 32'h8000_0008, 32'hABCD_0000);
      setrd(32'h8000_0008);
      total++; if (rd !== 32'd1) begin bad++; $display("FAIL baud_zero got=%h exp=1", rd); end
      tick(1'b0, 1'b1, 32'h8000_0008, 32'd4);
      va = 8'($urandom); vb = 8'($urandom);
      for (int i = 0; i < 136; i++) begin
         if (i == 0)       tick(1'b0, 1'b1, 32'h8000_0000, {24'd0, va});
         else if (i == 1)  tick(1'b0, 1'b1, 32'h8000_0000, {24'd0, vb});
         else if (i == 20) tick(1'b0, 1'b1, 32'h8000_0008, 32'd8);
         else              tick(1'b0, 1'b0, 32'd0, 32'd0);
         log_tx[i] = tx;
         total++; if (tx !== m_tx()) begin bad++; $display("FAIL baud_tx i=%0d got=%b exp=%b", i, tx, m_tx()); end
      end
      for (int i = 0; i < 8; i++) begin
         ga[i] = log_tx[1 + 4*(i+1) + 2];
         gb[i] = log_tx[41 + 8*(i+1) + 4];
      end
      total++; if (ga !== va) begin bad++; $display("FAIL baud_frame1 got=%h exp=%h", ga, va); end
      total++; if (gb !== vb) begin bad++; $display("FAIL baud_frame2 got=%h exp=%h", gb, vb); end
      total++;
      if (log_tx[40] !== 1'b1 || log_tx[41] !== 1'b0 || log_tx[48] !== 1'b0 || log_tx[120] !== 1'b1 || log_tx[121] !== 1'b1) begin
         bad++; $display("FAIL baud_frame2_len got=%b%b%b%b%b exp=10011", log_tx[40], log_tx[41], log_tx[48], log_tx[120], log_tx[121]);
      end
      setrd(32'h8000_0008);
      total++; if (rd !== 32'd8) begin bad++; $display("FAIL baud_rd8 got=%h exp=8", rd); end
   endtask

   task automatic test_reset_mid();
      bit quiet;
      tick(1'b0, 1'b1, 32'h8000_0000, 32'h0000_00F0);
      tick(1'b0, 1'b1, 32'h8000_0000, 32'h0000_003C);
      for (int i = 2; i < 33; i++) tick(1'b0, 1'b0, 32'd0, 32'd0);
      total++; if (tx !== m_tx()) begin bad++; $display("FAIL rm_pre got=%b exp=%b", tx, m_tx()); end
      tick(1'b1, 1'b0, 32'd0, 32'd0);
      total++; if (tx !== 1'b1) begin bad++; $display("FAIL rm_tx got=%b exp=1", tx); end
      setrd(32'h8000_0004);
      total++; if (rd !== 32'h2) begin bad++; $display("FAIL rm_status got=%h exp=2", rd); end
      setrd(32'h8000_0008);
      total++; if (rd !== 32'd16) begin bad++; $display("FAIL rm_baud got=%h exp=10", rd); end
      quiet = 1'b1;
      for (int i = 0; i < 200; i++) begin
         tick(1'b0, 1'b0, 32'd0, 32'd0);
         if (tx !== 1'b1) quiet = 1'b0;
      end
      total++; if (!quiet) begin bad++; $display("FAIL rm_quiet got=activity exp=idle"); end
   endtask

   task automatic test_cycle();
      logic [31:0] v, exp;
      tick(1'b0, 1'b1, 32'h8000_000C, 32'hFFFF_FFFE);
      tick(1'b0, 1'b0, 32'd0, 32'd0);
      tick(1'b0, 1'b0, 32'd0, 32'd0);
      setrd(32'h8000_000C);
      total++; if (rd !== 32'd0) begin bad++; $display("FAIL cyc_wrap got=%h exp=0", rd); end
      for (int i = 0; i < 4; i++) begin
         v = $urandom;
         tick(1'b0, 1'b1, 32'h8000_000C, v);
         for (int k = 0; k < i; k++) tick(1'b0, 1'b0, 32'd0, 32'd0);
`ifdef DMEM_CYCLE_COUNTER_EN
         exp = v + 32'(i);
`else
         exp = 32'd0;
`endif
         setrd(32'h8000_000C | ($urandom & 32'h7FFF_FFE3));
         total++; if (rd !== exp) begin bad++; $display("FAIL cyc_load i=%0d got=%h exp=%h", i, rd, exp); end
      end
   endtask

   task automatic test_random();
      logic [31:0] ad, ra;
      int op;
      for (int i = 0; i < 400; i++) begin
         op = $urandom_range(0, 5);
         case (op)
            0: begin ad = $urandom & 32'h7FFF_FFFF; tick(1'b0, 1'b1, ad, $urandom); waddr.push_back(ad); end
            1: tick(1'b0, 1'b1, 32'h8000_0000 | ($urandom & 32'h7FFF_FFE3), $urandom);
            2: tick(1'b0, 1'b1, 32'h8000_0008 | ($urandom & 32'h7FFF_FFE3), $urandom & 32'hFFFF_0003);
            3: tick(1'b0, 1'b0, $urandom, $urandom);
            4: tick(1'b0, 1'b1, 32'h8000_0000 | ($urandom & 32'h7FFF_FFE3) | (32'($urandom_range(4, 7)) << 2), $urandom);
            default: tick(1'b0, 1'b1, 32'h8000_000C, $urandom);
         endcase
         total++; if (tx !== m_tx()) begin bad++; $display("FAIL rnd_tx i=%0d got=%b exp=%b", i, tx, m_tx()); end
         if ($urandom_range(0, 1) == 0) ra = (waddr[$urandom_range(0, waddr.size() - 1)] & 32'h0000_00FC) | ($urandom & 32'h7FFF_FF03);
         else ra = 32'h8000_0000 | $urandom;
         setrd(ra);
         total++; if (rd !== m_rd(ra)) begin bad++; $display("FAIL rnd_rd a=%h got=%h exp=%h", ra, rd, m_rd(ra)); end
      end
   endtask

   initial begin
      reset = 1'b1; we = 1'b0; a = 32'd0; wd = 32'd0;
      test_reset();
      test_ram();
      test_single_frame();
      test_back_to_back();
      test_baud();
      test_reset_mid();
      test_cycle();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/dmem_mmio.md
# dmem_mmio

Data-side memory responder for the single-cycle MIPS core: services every load/store the datapath issues on its ALU-result address and store-data bus, returning read data combinationally in the same cycle. Low half of the address space is word RAM. High half is a memory-mapped peripheral block holding a FIFO-buffered 8N1 UART transmitter and, optionally, a free-running cycle counter. Sits beside the instruction memory at top level, wired to `aluout`, `writedata`, `memwrite` and `readdata`.

## Interface
- `RAM_AW`, 6: RAM word-address width; depth 2^RAM_AW words.
- `FIFO_AW`, 2: TX FIFO address width; depth 2^FIFO_AW bytes.
- `CLKS_PER_BIT`, 16: reset value of BAUD_DIV.
- `clk`  in  1  single clock, all state on rising edge.
- `reset`  in  1  synchronous, active-high.
- `we`  in  1  store strobe (core `memwrite`).
- `a`  in  32  byte address (core `aluout`); a[1:0] ignored.
- `wd`  in  32  store data (core `writedata`).
- `rd`  out  32  load data, combinational from `a` and current state.
- `tx`  out  1  UART serial line, idle high, registered.

## Operation
- a[31]=0: RAM. Word index a[RAM_AW+1:2]; higher bits ignored (address aliases modulo depth). Write on edge when `we`. RAM contents not cleared by reset.
- a[31]=1: MMIO, decoded on a[4:2]; all other upper bits ignored.
  - 0x8000_0000 UART_DATA: write pushes wd[7:0] into FIFO; read returns 0.
  - 0x8000_0004 UART_STATUS (RO): bit0 fifo_full, bit1 fifo_empty, bit2 tx_busy (serializer not IDLE); other bits 0.
  - 0x8000_0008 BAUD_DIV (RW, 16 bits, reads zero-extended): cycles per bit. Written value 0 stored as 1.
  - 0x8000_000C CYCLE: see Configuration.
  - Other offsets: read 0, write ignored.
- FIFO: push when full dropped silently (no stall, no error flag). Push and pop in same cycle when full: push accepted, count unchanged. Pointers wrap modulo depth.
- Serializer FSM: IDLE -> START -> DATA -> STOP -> IDLE.
  - IDLE: `tx`=1. If FIFO non-empty: pop head into shift register, latch BAUD_DIV into bit timer, go START.
  - START: `tx`=0 for one bit time.
  - DATA: 8 bits LSB first, one bit time each.
  - STOP: `tx`=1 for one bit time; then IDLE (which may pop immediately, giving back-to-back frames with no extra idle).
- One bit time = latched divisor cycles. BAUD_DIV writes mid-frame affect only the next frame.

## Timing
- Reset values: `tx`=1, FSM IDLE, FIFO empty (status=0x2), BAUD_DIV=CLKS_PER_BIT, CYCLE=0. `rd` follows the reset state in the cycle after reset.
- Loads: zero-cycle latency; `rd` combinational, reflects state after last edge (store and load to same address cannot share a cycle in the core).
- Store to UART_DATA at edge N with FSM IDLE and FIFO empty: status bit1 clears after N; pop at edge N+1; `tx` low from N+1 for D cycles. Full frame is 10*D cycles; `tx` high again at N+1+9D.
- tx_busy set from START entry until STOP ends.
- `reset` mid-frame: `tx` returns to 1 on the reset edge; FIFO contents discarded.

## Configuration
- `DMEM_CYCLE_COUNTER_EN` defined: CYCLE is a 32-bit counter, 0 at reset, +1 every cycle, wraps 0xFFFF_FFFF -> 0; read returns value; write loads wd.
- Not defined: no counter hardware; CYCLE reads 0, writes ignored.

## Test plan
- RAM: store 0xDEADBEEF to 0x0000_0010, load 0x0000_0010 and alias 0x0000_0110 (RAM_AW=6) -> both 0xDEADBEEF; unwritten word 0x14 untouched.
- Single frame, BAUD_DIV=4: store 0x55 to UART_DATA -> `tx` low 4 cycles, then 1,0,1,0,1,0,1,0 each 4 cycles, stop high 4 cycles; frame 40 cycles; status 0x6 during, 0x2 after.
- Back-to-back and overflow, depth 4: push 6 bytes 0x41..0x46 in consecutive stores -> first popped immediately, next 4 queued, 0x46 dropped; status bit0 set; five frames emitted contiguously, 0x46 never on line.
- BAUD_DIV write 0 -> reads 1; write 8 mid-frame -> current frame unchanged, next frame 80 cycles.
- Reset mid-frame (after 3 data bits) -> `tx`=1 next cycle, status 0x2, BAUD_DIV=16, no further frames.
- With `DMEM_CYCLE_COUNTER_EN`: write 0xFFFF_FFFE to CYCLE, read 2 cycles later -> 0x0000_0000; without macro -> always 0.
